// File: rtl/pacman_mover_pkg.sv
// Shared maze definitions: heading encodings, default maze borders and mover FSM states.
// Also used by the sprite renderer, so the encodings here must stay in step with it.
package pacman_mover_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam int unsigned BORDER_X_MIN_DEF = 1;
    localparam int unsigned BORDER_X_MAX_DEF = 28;
    localparam int unsigned BORDER_Y_MIN_DEF = 1;
    localparam int unsigned BORDER_Y_MAX_DEF = 28;

    typedef enum logic [2:0] {
        StIdle,
        StProbeTurn,
        StEvalTurn,
        StProbeFwd,
        StEvalFwd
    } mover_state_e;

endpackage

// File: rtl/pacman_neighbor.sv
// Combinational neighbour tile in a given heading, flagged when it falls outside the maze
// borders. The maze has no tunnel, so an out-of-range tile is always treated as blocked.
module pacman_neighbor
    import pacman_mover_pkg::*;
#(
    parameter int unsigned BORDER_X_MIN = BORDER_X_MIN_DEF,
    parameter int unsigned BORDER_X_MAX = BORDER_X_MAX_DEF,
    parameter int unsigned BORDER_Y_MIN = BORDER_Y_MIN_DEF,
    parameter int unsigned BORDER_Y_MAX = BORDER_Y_MAX_DEF
) (
    input  logic [4:0] x,
    input  logic [4:0] y,
    input  logic [1:0] dir,
    output logic [4:0] nx,
    output logic [4:0] ny,
    output logic       outside
);

    localparam logic [5:0] XMin = 6'(BORDER_X_MIN);
    localparam logic [5:0] XMax = 6'(BORDER_X_MAX);
    localparam logic [5:0] YMin = 6'(BORDER_Y_MIN);
    localparam logic [5:0] YMax = 6'(BORDER_Y_MAX);

    logic [5:0] nx6;
    logic [5:0] ny6;

    // 6-bit arithmetic: stepping below 0 gives 63 and above 31 gives 32, both out of range.
    always_comb begin
        nx6 = {1'b0, x};
        ny6 = {1'b0, y};
        case (dir)
            DIR_UP:    ny6 = {1'b0, y} - 6'd1;
            DIR_LEFT:  nx6 = {1'b0, x} - 6'd1;
            DIR_DOWN:  ny6 = {1'b0, y} + 6'd1;
            DIR_RIGHT: nx6 = {1'b0, x} + 6'd1;
            default:   ;
        endcase
    end

    assign outside = (nx6 < XMin) || (nx6 > XMax) || (ny6 < YMin) || (ny6 > YMax);
    assign nx      = nx6[4:0];
    assign ny      = ny6[4:0];

endmodule

// File: rtl/pacman_mover.sv
// Tile-stepping Pac-Man movement controller: paces steps from the frame strobe, buffers
// one joystick turn and probes the maze wall map before each turn and each forward move.
module pacman_mover
    import pacman_mover_pkg::*;
#(
    parameter int unsigned BORDER_X_MIN = BORDER_X_MIN_DEF,
    parameter int unsigned BORDER_X_MAX = BORDER_X_MAX_DEF,
    parameter int unsigned BORDER_Y_MIN = BORDER_Y_MIN_DEF,
    parameter int unsigned BORDER_Y_MAX = BORDER_Y_MAX_DEF,
    parameter int unsigned START_X      = 14,
    parameter int unsigned START_Y      = 23,
    parameter int unsigned MOVE_FRAMES  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic [1:0] joy_dir,
    input  logic       joy_valid,
    output logic [4:0] map_x,
    output logic [4:0] map_y,
    input  logic       map_wall,
    output logic [4:0] xpos,
    output logic [4:0] ypos,
    output logic [1:0] direction,
    output logic       moved,
    output logic       busy
);

    localparam logic [5:0] FrameLast = 6'(MOVE_FRAMES - 1);
    localparam logic [4:0] StartX    = 5'(START_X);
    localparam logic [4:0] StartY    = 5'(START_Y);

    mover_state_e state_q, state_d;
    logic [5:0]   frame_q, frame_d;
    logic         step_req_q, step_req_d;
    logic         pend_valid_q, pend_valid_d;
    logic [1:0]   pend_dir_q, pend_dir_d;
    logic [1:0]   dir_q, dir_d;
    logic [4:0]   xpos_q, xpos_d, ypos_q, ypos_d;
    logic [4:0]   map_x_q, map_x_d, map_y_q, map_y_d;
    logic         outside_q, outside_d;
    logic         moved_q, moved_d;

    logic [1:0]   test_dir;
    logic [4:0]   nb_x, nb_y;
    logic         nb_outside;
    logic         blocked;

    assign test_dir = (state_q == StProbeTurn) ? pend_dir_q : dir_q;
    assign blocked  = outside_q | map_wall;

    pacman_neighbor #(
        .BORDER_X_MIN(BORDER_X_MIN),
        .BORDER_X_MAX(BORDER_X_MAX),
        .BORDER_Y_MIN(BORDER_Y_MIN),
        .BORDER_Y_MAX(BORDER_Y_MAX)
    ) u_neighbor (
        .x      (xpos_q),
        .y      (ypos_q),
        .dir    (test_dir),
        .nx     (nb_x),
        .ny     (nb_y),
        .outside(nb_outside)
    );

    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        step_req_d   = step_req_q;
        pend_valid_d = pend_valid_q;
        pend_dir_d   = pend_dir_q;
        dir_d        = dir_q;
        xpos_d       = xpos_q;
        ypos_d       = ypos_q;
        map_x_d      = map_x_q;
        map_y_d      = map_y_q;
        outside_d    = outside_q;
        moved_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (step_req_q) begin
                    step_req_d = 1'b0;
                    state_d    = (pend_valid_q && pend_dir_q != dir_q) ? StProbeTurn : StProbeFwd;
                end
            end
            StProbeTurn, StProbeFwd: begin
                map_x_d   = nb_x;
                map_y_d   = nb_y;
                outside_d = nb_outside;
                state_d   = (state_q == StProbeTurn) ? StEvalTurn : StEvalFwd;
            end
            StEvalTurn: begin
                if (!blocked) begin
                    dir_d        = pend_dir_q;
                    pend_valid_d = 1'b0;
                end
                state_d = StProbeFwd;
            end
            StEvalFwd: begin
                // The probe address already holds the neighbour tile we would step onto.
                if (!blocked) begin
                    xpos_d  = map_x_q;
                    ypos_d  = map_y_q;
                    moved_d = 1'b1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A new frame tick and a fresh joystick sample both override the clears above.
        if (ce) begin
            if (frame_q == FrameLast) begin
                frame_d    = 6'd0;
                step_req_d = 1'b1;
            end else begin
                frame_d = frame_q + 6'd1;
            end
        end
        if (joy_valid) begin
            pend_dir_d   = joy_dir;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            frame_q      <= 6'd0;
            step_req_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_dir_q   <= DIR_RIGHT;
            dir_q        <= DIR_RIGHT;
            xpos_q       <= StartX;
            ypos_q       <= StartY;
            map_x_q      <= StartX;
            map_y_q      <= StartY;
            outside_q    <= 1'b0;
            moved_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            step_req_q   <= step_req_d;
            pend_valid_q <= pend_valid_d;
            pend_dir_q   <= pend_dir_d;
            dir_q        <= dir_d;
            xpos_q       <= xpos_d;
            ypos_q       <= ypos_d;
            map_x_q      <= map_x_d;
            map_y_q      <= map_y_d;
            outside_q    <= outside_d;
            moved_q      <= moved_d;
        end
    end

    assign map_x     = map_x_q;
    assign map_y     = map_y_q;
    assign xpos      = xpos_q;
    assign ypos      = ypos_q;
    assign direction = dir_q;
    assign moved     = moved_q;
    assign busy      = (state_q != StIdle);

endmodule
